// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// default register-address width and the x0 register address.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam int REG_AW_DEF = 5;

    localparam logic [REG_AW_DEF-1:0] X0 = '0;

endpackage : pipe_pkg

// File: rtl/lu_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Loads to x0 never stall.
module lu_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    assign rd_live = ex_mem_read && (ex_rd != REG_AW'(X0));
    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu      = rd_live && (rs1_hit || rs2_hit);

endmodule : lu_detect

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the 5-stage core (PC hold, IF/ID
// hold/flush, ID/EX bubble/freeze). Optional counters: HAZARD_CTRL_STATS_EN.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int REG_AW          = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              br_taken,
    input  logic              imem_ready,
    input  logic              dmem_busy,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              idex_hold
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // Post-branch flush counter: BR_FLUSH_CYCLES is limited to 1..3.
    localparam logic [1:0] BR_CNT_INIT = 2'(BR_FLUSH_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic       lu;

    logic       pc_hold_c;
    logic       ifid_hold_c;
    logic       ifid_flush_c;
    logic       idex_flush_c;
    logic       idex_hold_c;

    lu_detect #(
        .REG_AW (REG_AW)
    ) u_lu_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (lu)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        state_next   = state;
        cnt_next     = cnt;
        pc_hold_c    = 1'b0;
        ifid_hold_c  = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        idex_hold_c  = 1'b0;

        if (rst) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            state_next   = RUN;
            cnt_next     = '0;
        end else begin
            unique case (state)
                FLUSH: begin
                    // Any br_taken seen here belongs to a squashed instruction.
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    if (dmem_busy) begin
                        idex_hold_c = 1'b1;
                    end else if (cnt <= 2'd1) begin
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt - 2'd1;
                    end
                end

                default: begin
                    // RUN, and FREEZE which re-evaluates like RUN on release.
                    state_next = RUN;
                    if (dmem_busy) begin
                        pc_hold_c   = 1'b1;
                        ifid_hold_c = 1'b1;
                        idex_hold_c = 1'b1;
                        state_next  = FREEZE;
                    end else if (br_taken) begin
                        ifid_flush_c = 1'b1;
                        idex_flush_c = 1'b1;
                        if (BR_FLUSH_CYCLES > 1) begin
                            state_next = FLUSH;
                            cnt_next   = BR_CNT_INIT;
                        end
                    end else if (lu) begin
                        pc_hold_c    = 1'b1;
                        ifid_hold_c  = 1'b1;
                        idex_flush_c = 1'b1;
                    end else if (!imem_ready) begin
                        pc_hold_c    = 1'b1;
                        ifid_flush_c = 1'b1;
                    end
                end
            endcase
        end
    end

    // Flush always wins over hold at the IF/ID register.
    assign pc_hold    = pc_hold_c;
    assign ifid_hold  = ifid_hold_c && !ifid_flush_c;
    assign ifid_flush = ifid_flush_c;
    assign idex_flush = idex_flush_c;
    assign idex_hold  = idex_hold_c;

`ifdef HAZARD_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold)    stall_cnt <= stall_cnt + 32'd1;
            if (ifid_flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl with BR_FLUSH_CYCLES=2.
// Checks the statistics counters too when HAZARD_CTRL_STATS_EN is defined.
module tb_hazard_ctrl;

    localparam int AW = 5;

    typedef struct {
        string          name;
        logic           rst;
        logic [AW-1:0]  rs1;
        logic [AW-1:0]  rs2;
        logic           use1;
        logic           use2;
        logic [AW-1:0]  rd;
        logic           mr;
        logic           br;
        logic           imem;
        logic           dmem;
        logic [4:0]     exp;   // {pc_hold, ifid_hold, ifid_flush, idex_flush, idex_hold}
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read;
    logic          br_taken, imem_ready, dmem_busy;
    logic          pc_hold, ifid_hold, ifid_flush, idex_flush, idex_hold;
`ifdef HAZARD_CTRL_STATS_EN
    logic [31:0]   stall_cnt, flush_cnt;
    logic [31:0]   m_stall, m_flush;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .BR_FLUSH_CYCLES (2),
        .REG_AW          (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .br_taken    (br_taken),
        .imem_ready  (imem_ready),
        .dmem_busy   (dmem_busy),
        .pc_hold     (pc_hold),
        .ifid_hold   (ifid_hold),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .idex_hold   (idex_hold)
`ifdef HAZARD_CTRL_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare before the next edge, then clock.
    task automatic apply(input vec_t v);
        rst         = v.rst;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_use_rs1  = v.use1;
        id_use_rs2  = v.use2;
        ex_rd       = v.rd;
        ex_mem_read = v.mr;
        br_taken    = v.br;
        imem_ready  = v.imem;
        dmem_busy   = v.dmem;
        @(negedge clk);
        check(v.name, {27'd0, pc_hold, ifid_hold, ifid_flush, idex_flush, idex_hold},
              {27'd0, v.exp});
`ifdef HAZARD_CTRL_STATS_EN
        check({v.name, ".stall_cnt"}, stall_cnt, m_stall);
        check({v.name, ".flush_cnt"}, flush_cnt, m_flush);
        if (v.rst) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            m_stall = m_stall + {31'd0, v.exp[4]};
            m_flush = m_flush + {31'd0, v.exp[2]};
        end
`endif
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic r,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input logic u1, input logic u2, input logic [AW-1:0] rd,
                                input logic mr, input logic br, input logic im,
                                input logic dm, input logic [4:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2;
        v.rd = rd; v.mr = mr; v.br = br; v.imem = im; v.dmem = dm; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        //            name            rst rs1 rs2 u1 u2 rd mr br im dm  exp
        tbl.push_back(mk("reset",       1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00110));
        tbl.push_back(mk("idle",        0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("lu_rs2",      0, 1, 5, 0, 1, 5, 1, 0, 1, 0, 5'b11010));
        tbl.push_back(mk("lu_bubble",   0, 1, 5, 0, 1, 5, 0, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("load_x0",     0, 0, 2, 1, 0, 0, 1, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("lu_imiss",    0, 3, 2, 1, 0, 3, 1, 0, 0, 0, 5'b11010));
        tbl.push_back(mk("lu_unused",   0, 3, 2, 0, 0, 3, 1, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("imiss_1",     0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 5'b10100));
        tbl.push_back(mk("imiss_2",     0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 5'b10100));
        tbl.push_back(mk("br_t",        0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 5'b00110));
        tbl.push_back(mk("br_t1_ign",   0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 5'b00110));
        tbl.push_back(mk("br_t2_run",   0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("dbusy_lu_1",  0, 7, 2, 1, 0, 7, 1, 0, 1, 1, 5'b11001));
        tbl.push_back(mk("dbusy_lu_2",  0, 7, 2, 1, 0, 7, 1, 0, 1, 1, 5'b11001));
        tbl.push_back(mk("dbusy_lu_3",  0, 7, 2, 1, 0, 7, 1, 0, 1, 1, 5'b11001));
        tbl.push_back(mk("release_lu",  0, 7, 2, 1, 0, 7, 1, 0, 1, 0, 5'b11010));
        tbl.push_back(mk("idle_2",      0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("dbusy_br",    0, 1, 2, 0, 0, 0, 0, 1, 1, 1, 5'b11001));
        tbl.push_back(mk("release_br",  0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 5'b00110));
        tbl.push_back(mk("flush_dbusy", 0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 5'b00111));
        tbl.push_back(mk("flush_last",  0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00110));
        tbl.push_back(mk("idle_3",      0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("br_pre_rst",  0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 5'b00110));
        tbl.push_back(mk("rst_in_fl",   1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00110));
        tbl.push_back(mk("run_after",   0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
        tbl.push_back(mk("br_over_lu",  0, 4, 2, 1, 0, 4, 1, 1, 1, 0, 5'b00110));
        tbl.push_back(mk("fl_ign_lu",   0, 4, 2, 1, 0, 4, 1, 0, 0, 0, 5'b00110));
        tbl.push_back(mk("idle_4",      0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00000));

        // Bring the design out of an unknown state before the checked run.
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; br_taken = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
`ifdef HAZARD_CTRL_STATS_EN
        m_stall = '0;
        m_flush = '0;
`endif
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset in the middle of a freeze returns straight to RUN.
        apply(mk("frz_enter",  0, 1, 2, 0, 0, 0, 0, 0, 1, 1, 5'b11001));
        apply(mk("frz_rst",    1, 1, 2, 0, 0, 0, 0, 0, 1, 1, 5'b00110));
        apply(mk("frz_run",    0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'b00000));

        // lu held across a long freeze fires exactly once on release.
        apply(mk("hold_lu_1",  0, 6, 6, 0, 1, 6, 1, 0, 0, 1, 5'b11001));
        apply(mk("hold_lu_2",  0, 6, 6, 0, 1, 6, 1, 0, 0, 1, 5'b11001));
        apply(mk("hold_lu_rel",0, 6, 6, 0, 1, 6, 1, 0, 0, 0, 5'b11010));
        apply(mk("hold_lu_nxt",0, 6, 6, 0, 1, 6, 0, 0, 1, 0, 5'b00000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It drives PC hold, IF/ID hold/flush and ID/EX flush from load-use, taken-branch, instruction-fetch-miss and data-memory-busy conditions. It sits beside the IF/ID register, whose Write input (high = hold) and Flush input it owns. It also owns the PC write-enable and the ID/EX bubble.

Parameters:
- BR_FLUSH_CYCLES, 1, consecutive cycles IF/ID and ID/EX are flushed after a taken branch (1 = resolve in EX, 2 = resolve in MEM); legal values 1..3.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- id_rs1  in  REG_AW  rs1 of instruction in ID.
- id_rs2  in  REG_AW  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_AW  destination of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- br_taken  in  1  branch/jump taken, resolved this cycle.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_busy  in  1  data memory not complete; whole pipe must freeze.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  to IF/ID Write (1 = hold contents).
- ifid_flush  out  1  to IF/ID Flush (1 = zero contents).
- idex_flush  out  1  insert bubble into ID/EX.
- idex_hold  out  1  ID/EX, EX/MEM, MEM/WB hold (freeze).

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. While rst=1: state<=RUN, flush counter<=0; outputs forced pc_hold=0, ifid_hold=0, ifid_flush=1, idex_flush=1, idex_hold=0.
- Outputs are combinational from registered state plus current inputs (zero-latency hazard response); state updates on posedge.
- States: RUN, FLUSH, FREEZE.
- Load-use hazard (lu): ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)). A load to x0 never stalls.
- Priority, evaluated every cycle in RUN: dmem_busy > br_taken > lu > !imem_ready.
- RUN, dmem_busy=1: pc_hold=1, ifid_hold=1, idex_hold=1, no flushes. Next state FREEZE.
- RUN, br_taken=1: ifid_flush=1, idex_flush=1, pc_hold=0. Next state is FLUSH with cnt=BR_FLUSH_CYCLES-1 if BR_FLUSH_CYCLES>1, else RUN.
- RUN, lu=1: pc_hold=1, ifid_hold=1, idex_flush=1 for exactly one cycle. The following cycle sees the bubble in EX, so no repeat stall. A simultaneous imem miss is absorbed, since PC is held anyway.
- RUN, imem_ready=0 (no higher event): pc_hold=1, ifid_flush=1 (fetch bubble). ID/EX advances normally.
- FLUSH: ifid_flush=1, idex_flush=1 every cycle; cnt decrements, exit to RUN when cnt==0 at the clock edge. br_taken is ignored (it comes from a squashed instruction). dmem_busy in FLUSH freezes the counter and asserts idex_hold, with flushes still asserted.
- FREEZE: same outputs as RUN with dmem_busy. Stays while dmem_busy=1. On dmem_busy=0, outputs are evaluated exactly as in RUN that same cycle, so a held br_taken or lu is serviced on the release cycle; next state follows the RUN rules.
- Outputs never assert ifid_hold and ifid_flush together. Flush wins; hold is dropped.
- Reset mid-FLUSH or mid-FREEZE aborts to RUN next cycle with counter cleared.

Optional Feature:
- Macro HAZARD_CTRL_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] (cycles with pc_hold=1) and flush_cnt[31:0] (cycles with ifid_flush=1 outside reset). Both are zeroed on rst and wrap at 2^32-1 to 0.
- Undefined: no counters and no extra ports.

Decomposition:
- Shared package pipe_pkg: state encoding (RUN=2'd0, FLUSH=2'd1, FREEZE=2'd2), REG_AW default, X0 address constant.
- One natural sub-module: lu_detect, a pure comparator producing lu. Everything else lives in hazard_ctrl.

Test Plan:
- lw x5 in EX (ex_mem_read=1, ex_rd=5) with ID add reading rs2=5 -> one cycle of pc_hold=1, ifid_hold=1, idex_flush=1; next cycle all 0.
- ex_rd=0 with ex_mem_read=1 and id_rs1=0, id_use_rs1=1 -> no stall; all outputs 0.
- BR_FLUSH_CYCLES=2, br_taken pulse at T -> ifid_flush=idex_flush=1 at T and T+1; br_taken=1 at T+1 is ignored; RUN at T+2.
- dmem_busy high 3 cycles while lu is true -> pc_hold=ifid_hold=idex_hold=1 for 3 cycles, then the lu stall fires on the release cycle.
- imem_ready=0 for 2 cycles in RUN -> pc_hold=1, ifid_flush=1 both cycles, idex_flush=0.
- rst asserted in FLUSH with cnt=1 -> next cycle RUN; with HAZARD_CTRL_STATS_EN defined, stall_cnt=flush_cnt=0.
